// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage of the 8-bit core.
//
// Delays the writeback control word by CTRL_DELAY stages so it lines up with the
// registered data coming out of the memory stage. Selects the writeback value and
// owns the register file. Reports each commit on the wb_* outputs, and tracks the
// committed PC and a retired-instruction count.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   read_data, alu_result, pc_in      registered data from the memory stage (never delayed)
//   valid_in, rd, RegWrite,
//   MemtoReg, Link                    control word, delayed CTRL_DELAY stages
//   flush                             squash control entries still in the delay stages
//   rs1_addr/rs1_data,
//   rs2_addr/rs2_data                 combinational read ports with same-cycle write bypass
//   wb_valid, wb_we, wb_rd, wb_data   registered record of the last commit
//   pc_commit                         PC of the most recent committed instruction
//   retire_count                      committed-instruction counter, wraps at 16 bits
module writeback_stage #(
  parameter int DW         = 8,
  parameter int NREGS      = 8,
  parameter int AW         = 3,
  parameter int CTRL_DELAY = 1,
  parameter int R0_ZERO    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] read_data,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] pc_in,
  input  logic          valid_in,
  input  logic [AW-1:0] rd,
  input  logic          RegWrite,
  input  logic          MemtoReg,
  input  logic          Link,
  input  logic          flush,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] pc_commit,
  output logic [15:0]   retire_count
);

  logic          a_valid;
  logic [AW-1:0] a_rd;
  logic          a_regwrite;
  logic          a_memtoreg;
  logic          a_link;

  logic [DW-1:0] wv;
  logic          rf_we;
  logic [DW-1:0] regs [NREGS];

  function automatic logic [DW-1:0] wb_select(
    input logic          link,
    input logic          memtoreg,
    input logic [DW-1:0] pc,
    input logic [DW-1:0] rdata,
    input logic [DW-1:0] alu
  );
    if (link) begin
      return pc;
    end else if (memtoreg) begin
      return rdata;
    end else begin
      return alu;
    end
  endfunction

  // ---- control pipeline: input -> aligned (a_*) ----
  generate
    if (CTRL_DELAY == 0) begin : g_no_delay
      assign a_valid    = valid_in;
      assign a_rd       = rd;
      assign a_regwrite = RegWrite;
      assign a_memtoreg = MemtoReg;
      assign a_link     = Link;
    end else begin : g_delay
      logic          vld_p      [CTRL_DELAY];
      logic [AW-1:0] rd_p       [CTRL_DELAY];
      logic          regwrite_p [CTRL_DELAY];
      logic          memtoreg_p [CTRL_DELAY];
      logic          link_p     [CTRL_DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CTRL_DELAY; i++) begin
            vld_p[i]      <= 1'b0;
            rd_p[i]       <= '0;
            regwrite_p[i] <= 1'b0;
            memtoreg_p[i] <= 1'b0;
            link_p[i]     <= 1'b0;
          end
        end else begin
          vld_p[0]      <= valid_in & ~flush;
          rd_p[0]       <= rd;
          regwrite_p[0] <= RegWrite;
          memtoreg_p[0] <= MemtoReg;
          link_p[0]     <= Link;
          for (int i = 1; i < CTRL_DELAY; i++) begin
            vld_p[i]      <= vld_p[i-1] & ~flush;
            rd_p[i]       <= rd_p[i-1];
            regwrite_p[i] <= regwrite_p[i-1];
            memtoreg_p[i] <= memtoreg_p[i-1];
            link_p[i]     <= link_p[i-1];
          end
        end
      end

      assign a_valid    = vld_p[CTRL_DELAY-1];
      assign a_rd       = rd_p[CTRL_DELAY-1];
      assign a_regwrite = regwrite_p[CTRL_DELAY-1];
      assign a_memtoreg = memtoreg_p[CTRL_DELAY-1];
      assign a_link     = link_p[CTRL_DELAY-1];
    end
  endgenerate

  // ---- aligned stage: value select and commit ----
  assign wv    = wb_select(a_link, a_memtoreg, pc_in, read_data, alu_result);
  assign rf_we = a_valid & a_regwrite & ~((R0_ZERO != 0) && (a_rd == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[a_rd] <= wv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      pc_commit    <= '0;
      retire_count <= '0;
    end else if (a_valid) begin
      wb_valid     <= 1'b1;
      wb_we        <= rf_we;
      wb_rd        <= a_rd;
      wb_data      <= wv;
      pc_commit    <= pc_in;
      retire_count <= retire_count + 16'd1;
    end else begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
    end
  end

  // ---- read ports: combinational, bypassing this cycle's write ----
  always_comb begin
    rs1_data = regs[rs1_addr];
    if ((R0_ZERO != 0) && (rs1_addr == '0)) begin
      rs1_data = '0;
    end else if (rf_we && (a_rd == rs1_addr)) begin
      rs1_data = wv;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if ((R0_ZERO != 0) && (rs2_addr == '0)) begin
      rs2_data = '0;
    end else if (rf_we && (a_rd == rs2_addr)) begin
      rs2_data = wv;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int CD = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] read_data, alu_result, pc_in;
  logic       valid_in;
  logic [2:0] rd;
  logic       RegWrite, MemtoReg, Link, flush;
  logic [2:0] rs1_addr, rs2_addr;
  logic [7:0] rs1_data, rs2_data;
  logic       wb_valid, wb_we;
  logic [2:0] wb_rd;
  logic [7:0] wb_data, pc_commit;
  logic [15:0] retire_count;

  writeback_stage #(.DW(8), .NREGS(8), .AW(3), .CTRL_DELAY(CD), .R0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_data(read_data), .alu_result(alu_result), .pc_in(pc_in),
    .valid_in(valid_in), .rd(rd), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Link(Link), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_commit(pc_commit), .retire_count(retire_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Behavioural model: a queue of issued instructions waiting CD cycles, an
  // architectural register array, and the last-commit record.
  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       rw;
    bit       m2r;
    bit       lnk;
  } ent_t;

  ent_t     q[$];
  bit [7:0] m_regs [8];
  bit       m_wb_valid, m_wb_we;
  bit [2:0] m_wb_rd;
  bit [7:0] m_wb_data, m_pc;
  bit [15:0] m_cnt;

  function automatic bit [7:0] exp_read(input bit [2:0] addr, input ent_t a,
                                        input bit [7:0] v, input bit we);
    if (addr == 0) return 8'h00;
    if (a.v && we && a.rd == addr) return v;
    return m_regs[addr];
  endfunction

  initial begin
    ent_t     a, n;
    bit [7:0] v;
    bit       we;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        for (int i = 0; i < CD; i++) begin
          n = '{v: 1'b0, rd: 3'd0, rw: 1'b0, m2r: 1'b0, lnk: 1'b0};
          q.push_back(n);
        end
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_wb_valid = 0; m_wb_we = 0; m_wb_rd = 0; m_wb_data = 0; m_pc = 0; m_cnt = 0;
      end
      a  = q[0];
      v  = a.lnk ? pc_in : (a.m2r ? read_data : alu_result);
      we = a.v && a.rw && (a.rd != 0);
      chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, m_wb_valid});
      chk("m_wb_we", {31'd0, wb_we}, {31'd0, m_wb_we});
      chk("m_wb_rd", {29'd0, wb_rd}, {29'd0, m_wb_rd});
      chk("m_wb_data", {24'd0, wb_data}, {24'd0, m_wb_data});
      chk("m_pc_commit", {24'd0, pc_commit}, {24'd0, m_pc});
      chk("m_retire_count", {16'd0, retire_count}, {16'd0, m_cnt});
      chk("m_rs1_data", {24'd0, rs1_data}, {24'd0, exp_read(rs1_addr, a, v, we)});
      chk("m_rs2_data", {24'd0, rs2_data}, {24'd0, exp_read(rs2_addr, a, v, we)});
      if (rst_n) begin
        // Predict the state after the coming posedge.
        void'(q.pop_front());
        if (a.v) begin
          if (we) m_regs[a.rd] = v;
          m_wb_valid = 1; m_wb_we = we; m_wb_rd = a.rd; m_wb_data = v;
          m_pc = pc_in; m_cnt = m_cnt + 16'd1;
        end else begin
          m_wb_valid = 0; m_wb_we = 0;
        end
        if (flush) foreach (q[i]) q[i].v = 1'b0;
        n = '{v: valid_in & ~flush, rd: rd, rw: RegWrite, m2r: MemtoReg, lnk: Link};
        q.push_back(n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; read_data = 0; alu_result = 0; pc_in = 0; valid_in = 0; rd = 0;
    RegWrite = 0; MemtoReg = 0; Link = 0; flush = 0; rs1_addr = 0; rs2_addr = 0;

    // Reset state: every register reads zero on both ports.
    #1;
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      rs2_addr = 3'(7 - i);
      #1;
      chk("reset_rs1", {24'd0, rs1_data}, 32'h00);
      chk("reset_rs2", {24'd0, rs2_data}, 32'h00);
    end
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_pc_commit", {24'd0, pc_commit}, 32'h00);
    chk("reset_retire", {16'd0, retire_count}, 32'd0);
    step();
    rst_n = 1;
    step();

    // Load through the delay stage, with same-cycle bypass.
    valid_in = 1; rd = 3; RegWrite = 1; MemtoReg = 1; Link = 0; read_data = 8'h11;
    alu_result = 8'hEE; pc_in = 8'h10;
    step();
    valid_in = 0; read_data = 8'h5A; rs1_addr = 3; rs2_addr = 1;
    #1;
    chk("bypass_rs1", {24'd0, rs1_data}, 32'h5A);
    step();
    chk("load_wb_data", {24'd0, wb_data}, 32'h5A);
    chk("load_wb_rd", {29'd0, wb_rd}, 32'd3);
    chk("load_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("load_retire", {16'd0, retire_count}, 32'd1);
    chk("load_reg3", {24'd0, rs1_data}, 32'h5A);

    // Link overrides MemtoReg.
    valid_in = 1; rd = 7; RegWrite = 1; MemtoReg = 1; Link = 1;
    step();
    valid_in = 0; pc_in = 8'h42; read_data = 8'h99; alu_result = 8'h77;
    step();
    rs1_addr = 7;
    #1;
    chk("link_reg7", {24'd0, rs1_data}, 32'h42);
    chk("link_pc_commit", {24'd0, pc_commit}, 32'h42);
    chk("link_retire", {16'd0, retire_count}, 32'd2);

    // Write to r0 is dropped but still retires.
    valid_in = 1; rd = 0; RegWrite = 1; MemtoReg = 0; Link = 0;
    step();
    valid_in = 0; alu_result = 8'hFF; pc_in = 8'h50;
    step();
    rs1_addr = 0;
    #1;
    chk("r0_read", {24'd0, rs1_data}, 32'h00);
    chk("r0_wb_we", {31'd0, wb_we}, 32'd0);
    chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("r0_retire", {16'd0, retire_count}, 32'd3);

    // Flush: aligned entry commits, incoming entry is dropped.
    valid_in = 1; rd = 1; RegWrite = 1; MemtoReg = 0; Link = 0; alu_result = 8'h20;
    step();
    rd = 2; alu_result = 8'h33;
    step();
    flush = 1; rd = 4; alu_result = 8'h44;
    step();
    flush = 0; valid_in = 0; alu_result = 8'h55;
    #1;
    chk("flush_retire_a", {16'd0, retire_count}, 32'd5);
    chk("flush_wb_rd", {29'd0, wb_rd}, 32'd2);
    chk("flush_wb_data", {24'd0, wb_data}, 32'h44);
    step();
    rs1_addr = 2; rs2_addr = 4;
    #1;
    chk("flush_retire_b", {16'd0, retire_count}, 32'd5);
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_reg2", {24'd0, rs1_data}, 32'h44);
    chk("flush_reg4", {24'd0, rs2_data}, 32'h00);

    // Drive retire_count to 0xFFFF, then wrap.
    valid_in = 1; rd = 5; RegWrite = 0;
    for (int i = 0; i < 65530; i++) begin
      pc_in = 8'(i);
      step();
    end
    valid_in = 0;
    step();
    chk("cnt_ffff", {16'd0, retire_count}, 32'h0000FFFF);
    valid_in = 1; pc_in = 8'hA5;
    step();
    valid_in = 0;
    step();
    chk("cnt_wrap", {16'd0, retire_count}, 32'h0);
    chk("cnt_wrap_pc", {24'd0, pc_commit}, 32'hA5);

    // Asynchronous reset with an entry in flight.
    valid_in = 1; rd = 6; RegWrite = 1; MemtoReg = 0; alu_result = 8'h77;
    rs1_addr = 7; rs2_addr = 3;
    step();
    chk("pre_rst_reg7", {24'd0, rs1_data}, 32'h42);
    rst_n = 0;
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", {24'd0, wb_data}, 32'h00);
    chk("rst_pc_commit", {24'd0, pc_commit}, 32'h00);
    chk("rst_retire", {16'd0, retire_count}, 32'd0);
    chk("rst_reg7", {24'd0, rs1_data}, 32'h00);
    chk("rst_reg3", {24'd0, rs2_data}, 32'h00);
    valid_in = 0;
    step();
    rst_n = 1;
    rs1_addr = 6;
    step();
    step();
    chk("post_rst_retire", {16'd0, retire_count}, 32'd0);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_reg6", {24'd0, rs1_data}, 32'h00);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
